// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Branch and jump targets resolve in decode from pc_d, so the word in fetch is always the delay slot.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        addr_err_d
);

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    logic signed [31:0] br_off_p0;
    logic [31:0]        br_tgt_p0;
    logic [31:0]        j_tgt_p0;
    logic [31:0]        npc_p0;
    logic               fetch_err_p0;

    // F stage: next-PC selection and fetch address check
    always_comb begin
        br_off_p0    = {{14{imm16[15]}}, imm16, 2'b00};
        br_tgt_p0    = pc_d + 32'd4 + $unsigned(br_off_p0);
        j_tgt_p0     = {pc_d[31:28], instr_index, 2'b00};
        npc_p0       = pc_f + 32'd4;
        case (npc_sel)
            2'b01:   npc_p0 = br_tgt_p0;
            2'b10:   npc_p0 = j_tgt_p0;
            2'b11:   npc_p0 = jr_target;
            default: npc_p0 = pc_f + 32'd4;
        endcase
        fetch_err_p0 = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LAST);
    end

    // F -> D boundary: PC register and IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f       <= PC_RESET;
            instr_d    <= 32'h0000_0000;
            pc_d       <= 32'h0000_0000;
            valid_d    <= 1'b0;
            addr_err_d <= 1'b0;
        end else if (!stall) begin
            pc_f       <= npc_p0;
            instr_d    <= fetch_err_p0 ? 32'h0000_0000 : instr_f;
            pc_d       <= pc_f;
            valid_d    <= 1'b1;
            addr_err_d <= fetch_err_p0;
        end
    end

    assign pc8_d = pc_d + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed steps push expected IF state, a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] instr_index = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] instr_f;
    logic [31:0] pc_f, instr_d, pc_d, pc8_d;
    logic        valid_d, addr_err_d;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr;
        logic [31:0] pc_d;
        logic        valid;
        logic        err;
        int          id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int step_id = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .valid_d     (valid_d),
        .addr_err_d  (addr_err_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign instr_f = mem(pc_f);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] epf, input logic [31:0] epd, input logic ev, input logic ee);
        exp_t e;
        e.pc_f  = epf;
        e.pc_d  = epd;
        e.valid = ev;
        e.err   = ee;
        e.instr = (ev && !ee) ? mem(epd) : 32'h0;
        e.id    = step_id;
        q.push_back(e);
        step_id++;
    endtask

    // Drive one cycle of decode feedback, then queue the state expected after the edge.
    task automatic step(input logic st, input logic [1:0] sel, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jr,
                        input logic [31:0] epf, input logic [31:0] epd,
                        input logic ev, input logic ee);
        stall       = st;
        npc_sel     = sel;
        imm16       = imm;
        instr_index = idx;
        jr_target   = jr;
        @(posedge clk);
        push(epf, epd, ev, ee);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("pc_f#%0d", e.id), pc_f, e.pc_f);
            chk($sformatf("pc_d#%0d", e.id), pc_d, e.pc_d);
            chk($sformatf("pc8_d#%0d", e.id), pc8_d, e.pc_d + 32'd8);
            chk($sformatf("instr_d#%0d", e.id), instr_d, e.instr);
            chk($sformatf("valid_d#%0d", e.id), {31'b0, valid_d}, {31'b0, e.valid});
            chk($sformatf("addr_err_d#%0d", e.id), {31'b0, addr_err_d}, {31'b0, e.err});
        end
    end

    initial begin
        #1 reset = 1'b0;
        push(32'h3000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;

        // sequential fetch out of reset
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 1, 0);
        // backward branch from pc_d=3008, delay slot 300C lands in D
        step(0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 32'h300C, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3010, 32'h300C, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3014, 32'h3010, 1, 0);
        // jump from pc_d=3010
        step(0, 2'b10, 16'h0, 26'h0000C40, 32'h0, 32'h3100, 32'h3014, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3104, 32'h3100, 1, 0);
        // stall holds everything, jr ignored until stall drops
        step(1, 2'b11, 16'h0, 26'h0, 32'h3200, 32'h3104, 32'h3100, 1, 0);
        step(1, 2'b11, 16'h0, 26'h0, 32'h3200, 32'h3104, 32'h3100, 1, 0);
        step(0, 2'b11, 16'h0, 26'h0, 32'h3200, 32'h3200, 32'h3104, 1, 0);
        // misaligned and out-of-range fetches
        step(0, 2'b11, 16'h0, 26'h0, 32'h3202, 32'h3202, 32'h3200, 1, 0);
        step(0, 2'b11, 16'h0, 26'h0, 32'h4000, 32'h4000, 32'h3202, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4004, 32'h4000, 1, 1);
        step(0, 2'b11, 16'h0, 26'h0, 32'h3FFC, 32'h3FFC, 32'h4004, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4000, 32'h3FFC, 1, 0);
        step(0, 2'b11, 16'h0, 26'h0, 32'h2FFC, 32'h2FFC, 32'h4000, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h2FFC, 1, 1);
        // 32-bit wrap of the sequential adder
        step(0, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3000, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 1);
        step(0, 2'b11, 16'h0, 26'h0, 32'h3040, 32'h3040, 32'h0000_0000, 1, 1);
        step(1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3040, 32'h0000_0000, 1, 1);

        // asynchronous reset mid-stall, checked before the next clock edge
        reset = 1'b0;
        #1;
        chk("async_pc_f", pc_f, 32'h3000);
        chk("async_valid_d", {31'b0, valid_d}, 32'h0);
        chk("async_pc_d", pc_d, 32'h0);
        chk("async_instr_d", instr_d, 32'h0);
        chk("async_err_d", {31'b0, addr_err_d}, 32'h0);
        chk("async_pc8_d", pc8_d, 32'h8);
        stall     = 1'b0;
        npc_sel   = 2'b11;
        jr_target = 32'h3200;
        @(posedge clk);
        push(32'h3000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;

        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 1, 0);
        step(0, 2'b01, 16'h0001, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
